// File: rtl/spi_burst_ram.sv
// Command-decoded RAM slave for the SPI front end: independent write/read pointers,
// optional burst auto-increment, tx_valid/tx_ready read handshake and sticky error flags.
module spi_burst_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err_ovf,
    output logic              err_addr,
    input  logic              err_clr
);

    localparam logic [1:0] OP_SET_WADDR = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_SET_RADDR = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [1:0]        op;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr;
    logic              wr_cmd;
    logic              rd_cmd;
    logic              rd_accept;
    logic              rd_drop;
    logic              wr_in;
    logic              rd_in;
    logic              addr_err;

    // In-range pointers wrap at the last word; out-of-range ones run on to the
    // natural 2**ADDR_W rollover.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        if (AUTO_INC == 0) return p;
        if (p == LAST) return '0;
        return p + ADDR_W'(1);
    endfunction

    always_comb begin
        op        = din[DATA_W+1:DATA_W];
        payload   = din[DATA_W-1:0];
        addr      = din[ADDR_W-1:0];
        wr_cmd    = rx_valid && (op == OP_WRITE);
        rd_cmd    = rx_valid && (op == OP_READ);
        rd_accept = rd_cmd && (!tx_valid || tx_ready);
        rd_drop   = rd_cmd && tx_valid && !tx_ready;
        wr_in     = {1'b0, wr_ptr} < DEPTH;
        rd_in     = {1'b0, rd_ptr} < DEPTH;
        addr_err  = (wr_cmd && !wr_in) || (rd_accept && !rd_in);
    end

    // Array is never reset; the rst_n gate keeps a command on a reset edge from landing.
    always_ff @(posedge clk) begin
        if (rst_n && wr_cmd && wr_in)
            mem[wr_ptr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            if (rx_valid && op == OP_SET_WADDR) wr_ptr <= addr;
            if (wr_cmd)                         wr_ptr <= next_ptr(wr_ptr);
            if (rx_valid && op == OP_SET_RADDR) rd_ptr <= addr;

            // An accepted read reloads dout in the same edge a consumer takes the old word.
            if (rd_accept) begin
                dout     <= rd_in ? mem[rd_ptr] : '0;
                tx_valid <= 1'b1;
                rd_ptr   <= next_ptr(rd_ptr);
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            if (err_clr) begin
                err_ovf  <= 1'b0;
                err_addr <= 1'b0;
            end
            if (rd_drop)  err_ovf  <= 1'b1;
            if (addr_err) err_addr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Bench for spi_burst_ram: three builds (full depth, depth 200, no auto-increment)
// share one stimulus stream and are each checked against an array-based model.
module tb_spi_burst_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;
    logic       err_clr;

    logic [7:0] dout_w [3];
    logic       tv_w   [3];
    logic       eo_w   [3];
    logic       ea_w   [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_w[0]), .tx_valid(tv_w[0]), .err_ovf(eo_w[0]), .err_addr(ea_w[0]),
        .err_clr(err_clr));

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_w[1]), .tx_valid(tv_w[1]), .err_ovf(eo_w[1]), .err_addr(ea_w[1]),
        .err_clr(err_clr));

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .dout(dout_w[2]), .tx_valid(tv_w[2]), .err_ovf(eo_w[2]), .err_addr(ea_w[2]),
        .err_clr(err_clr));

    // Reference model state per build
    int         m_depth [3] = '{256, 200, 256};
    bit         m_inc   [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] m_mem   [3][256];
    int         m_wp    [3];
    int         m_rp    [3];
    logic [7:0] m_dout  [3];
    bit         m_tv    [3];
    bit         m_eo    [3];
    bit         m_ea    [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int adv(int k, int p);
        if (!m_inc[k]) return p;
        if (p < m_depth[k]) return (p + 1) % m_depth[k];
        return (p + 1) % 256;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_wp[k] = 0; m_rp[k] = 0; m_dout[k] = 8'h00;
            m_tv[k] = 1'b0; m_eo[k] = 1'b0; m_ea[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [1:0] op;
        logic [7:0] pay;
        bit was_tv, set_ea, set_eo;
        op  = din[9:8];
        pay = din[7:0];
        for (int k = 0; k < 3; k++) begin
            was_tv = m_tv[k];
            set_ea = 1'b0;
            set_eo = 1'b0;
            if (tx_ready) m_tv[k] = 1'b0;
            if (rx_valid) begin
                case (op)
                    2'd0: m_wp[k] = int'(pay);
                    2'd1: begin
                        if (m_wp[k] < m_depth[k]) m_mem[k][m_wp[k]] = pay;
                        else set_ea = 1'b1;
                        m_wp[k] = adv(k, m_wp[k]);
                    end
                    2'd2: m_rp[k] = int'(pay);
                    default: begin
                        if (!was_tv || tx_ready) begin
                            if (m_rp[k] < m_depth[k]) m_dout[k] = m_mem[k][m_rp[k]];
                            else begin m_dout[k] = 8'h00; set_ea = 1'b1; end
                            m_tv[k] = 1'b1;
                            m_rp[k] = adv(k, m_rp[k]);
                        end else begin
                            set_eo = 1'b1;
                        end
                    end
                endcase
            end
            if (err_clr) begin m_eo[k] = 1'b0; m_ea[k] = 1'b0; end
            if (set_ea) m_ea[k] = 1'b1;
            if (set_eo) m_eo[k] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dout[%0d]", k),     32'(dout_w[k]), 32'(m_dout[k]));
            chk($sformatf("tx_valid[%0d]", k), 32'(tv_w[k]),   32'(m_tv[k]));
            chk($sformatf("err_ovf[%0d]", k),  32'(eo_w[k]),   32'(m_eo[k]));
            chk($sformatf("err_addr[%0d]", k), 32'(ea_w[k]),   32'(m_ea[k]));
        end
    endtask

    // Drive one cycle from a negedge; model and compare just after the rising edge.
    task automatic cyc(input logic [1:0] op, input logic [7:0] pay, input logic rv,
                       input logic tr, input logic ec);
        din = {op, pay}; rx_valid = rv; tx_ready = tr; err_clr = ec;
        @(posedge clk);
        if (rst_n) model_step();
        #1 compare_all();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; din = '0; rx_valid = 1'b0; tx_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Fill every word so nothing unknown is ever read back
        for (int a = 0; a < 256; a++) begin
            cyc(2'd0, 8'(a), 1'b1, 1'b0, 1'b0);
            cyc(2'd1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        end
        cyc(2'd0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Burst write then back-to-back reads
        cyc(2'd0, 8'h10, 1'b1, 1'b0, 1'b0);
        cyc(2'd1, 8'hA1, 1'b1, 1'b0, 1'b0);
        cyc(2'd1, 8'hA2, 1'b1, 1'b0, 1'b0);
        cyc(2'd1, 8'hA3, 1'b1, 1'b0, 1'b0);
        cyc(2'd2, 8'h10, 1'b1, 1'b0, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("burst_d0", 32'(dout_w[0]), 32'hA1); chk("burst_v0", 32'(tv_w[0]), 32'h1);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("burst_d1", 32'(dout_w[0]), 32'hA2); chk("burst_v1", 32'(tv_w[0]), 32'h1);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("burst_d2", 32'(dout_w[0]), 32'hA3); chk("burst_v2", 32'(tv_w[0]), 32'h1);
        chk("noinc_d", 32'(dout_w[2]), 32'hA3);
        cyc(2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("burst_end", 32'(tv_w[0]), 32'h0);

        // Asynchronous reset while holding unconsumed read data
        cyc(2'd2, 8'h12, 1'b1, 1'b0, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_v", 32'(tv_w[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_v", 32'(tv_w[0]), 32'h0);
        chk("rst_d", 32'(dout_w[0]), 32'h0);
        compare_all();
        @(negedge clk);
        cyc(2'd1, 8'h77, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc(2'd2, 8'h10, 1'b1, 1'b1, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("post_rst_d", 32'(dout_w[0]), 32'hA1);

        // Wrap-around at the top of a full-depth array
        cyc(2'd0, 8'hFF, 1'b1, 1'b1, 1'b0);
        cyc(2'd1, 8'h11, 1'b1, 1'b0, 1'b0);
        cyc(2'd1, 8'h22, 1'b1, 1'b0, 1'b0);
        cyc(2'd2, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("wrap_d0", 32'(dout_w[0]), 32'h11);
        chk("oor_ff",  32'(dout_w[1]), 32'h00);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("wrap_d1", 32'(dout_w[0]), 32'h22);
        cyc(2'd0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Backpressure: second read dropped, pointer advanced once
        cyc(2'd2, 8'h10, 1'b1, 1'b0, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("bp_v", 32'(tv_w[0]), 32'h1); chk("bp_d", 32'(dout_w[0]), 32'hA1);
        cyc(2'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("bp_ovf", 32'(eo_w[0]), 32'h1); chk("bp_hold", 32'(dout_w[0]), 32'hA1);
        cyc(2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("bp_drain", 32'(tv_w[0]), 32'h0);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("bp_next", 32'(dout_w[0]), 32'hA2);

        // Out-of-range access on the depth-200 build, then clear
        cyc(2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(2'd0, 8'hD0, 1'b1, 1'b1, 1'b0);
        cyc(2'd1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk("oor_wr_err", 32'(ea_w[1]), 32'h1);
        chk("inr_wr_ok",  32'(ea_w[0]), 32'h0);
        cyc(2'd2, 8'hD0, 1'b1, 1'b1, 1'b0);
        cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("oor_rd", 32'(dout_w[1]), 32'h00);
        chk("inr_rd", 32'(dout_w[0]), 32'h55);
        cyc(2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("clr_ea", 32'(ea_w[1]), 32'h0); chk("clr_eo", 32'(eo_w[1]), 32'h0);

        // Non-incrementing build rereads the same word
        cyc(2'd0, 8'h05, 1'b1, 1'b1, 1'b0);
        cyc(2'd1, 8'h3C, 1'b1, 1'b1, 1'b0);
        cyc(2'd2, 8'h05, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'd3, 8'h00, 1'b1, 1'b1, 1'b0);
            chk($sformatf("noinc_rd%0d", i), 32'(dout_w[2]), 32'h3C);
        end

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] pay;
            pay = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom);
            cyc(2'($urandom), pay, ($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1 model_reset();
                compare_all();
                #1 rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
